// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment digit scanner.
//   DIGIT_W      width of one displayed digit value
//   MAX_DIGITS   largest supported digit count
//   ANODE_OFF    all-anodes-off pattern (slice to NUM_DIGITS bits)
//   scan_state_e two-phase scan FSM state
//   cnt_width()  slot counter width for a given REFRESH_DIV
//   idx_width()  digit index width for a given NUM_DIGITS
`timescale 1ns/1ps
package seven_seg_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_e;

    function automatic int cnt_width(input int refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle of the seven-segment scanner.
//   digits_in    packed digit values, digit 0 in the low nibble
//   load         1-cycle strobe capturing digits_in into the pending buffer
//   digit_en     per-digit enable, 1 = may light
//   encoded      value of the digit in the current slot (to cathode decoder)
//   anode        active-low digit enables
//   frame_start  1-cycle pulse on the first cycle of each frame
// Modports: master = data producer / display driver user, slave = scanner.
`timescale 1ns/1ps
interface seven_seg_scan_if
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);
    logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
    logic                          load;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic [DIGIT_W-1:0]            encoded;
    logic [NUM_DIGITS-1:0]         anode;
    logic                          frame_start;

    modport master (
        output digits_in, load, digit_en,
        input  encoded, anode, frame_start
    );

    modport slave (
        input  digits_in, load, digit_en,
        output encoded, anode, frame_start
    );

endinterface

// File: rtl/seg_refresh_timer.sv
// Digit-slot timer: counts 0..REFRESH_DIV-1 and wraps.
//   clk, rst_n   clock, asynchronous active-low reset
//   slot_wrap    high in the last cycle of a slot (counter returns to 0 next)
//   show_start   high in the last blank cycle (anode may assert next)
`timescale 1ns/1ps
module seg_refresh_timer
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_wrap,
    output logic show_start
);

    localparam int CNT_W = cnt_width(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        slot_wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        show_start = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
        cnt_d      = slot_wrap ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment digit scanner.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          seven_seg_scan_if.slave: digits_in/load/digit_en in,
//                encoded/anode/frame_start out (all outputs registered)
// Each slot starts with BLANK_CYCLES of all anodes off so the external
// registered decoder settles before the anode of the new digit asserts.
// New data is double-buffered and only committed at the frame boundary.
// Build option: define SEG_LZ_BLANK_EN to blank leading zeros (digit 0 is
// never blanked); leading zeros are judged on the committed buffer.
`timescale 1ns/1ps
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seven_seg_scan_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int BUF_W = DIGIT_W * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    logic                  slot_wrap, show_start, frame_wrap;
    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUF_W-1:0]      active_q, active_d;
    logic [BUF_W-1:0]      pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [DIGIT_W-1:0]    encoded_q, encoded_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0] lit_mask;
`ifdef SEG_LZ_BLANK_EN
    logic                  zero_above;
`endif

    seg_refresh_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_wrap  (slot_wrap),
        .show_start (show_start)
    );

    // Last cycle of the last slot: the edge ending it starts a new frame.
    assign frame_wrap = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin : data_path
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        // Commit uses the pending value held before this cycle; a load in
        // the same cycle re-arms pending for the following frame.
        if (frame_wrap && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end
        if (bus.load) begin
            pending_d       = bus.digits_in;
            pending_valid_d = 1'b1;
        end
    end

    always_comb begin : lit_rule
        lit_mask = bus.digit_en;
`ifdef SEG_LZ_BLANK_EN
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (active_d[i*DIGIT_W +: DIGIT_W] == '0);
            if (zero_above) begin
                lit_mask[i] = 1'b0;
            end
        end
`endif
    end

    // Outputs are computed from next-cycle state so the registered outputs
    // line up with the slot counter and FSM state they describe.
    always_comb begin : scan_fsm
        state_d       = state_q;
        idx_d         = idx_q;
        encoded_d     = encoded_q;
        anode_d       = ANODE_ALL_OFF;
        frame_start_d = frame_wrap;

        unique case (state_q)
            ST_BLANK: if (show_start) state_d = ST_SHOW;
            ST_SHOW:  if (slot_wrap)  state_d = ST_BLANK;
            default:                  state_d = ST_BLANK;
        endcase

        if (slot_wrap) begin
            idx_d     = frame_wrap ? '0 : idx_q + IDX_W'(1);
            encoded_d = active_d[idx_d*DIGIT_W +: DIGIT_W];
        end

        if (state_d == ST_SHOW && lit_mask[idx_d]) begin
            anode_d[idx_d] = 1'b0;
        end
    end

    // NOTE: the display buffers are reset along with the control state so
    // a fresh start shows zeros rather than undefined values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_BLANK;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            encoded_q       <= '0;
            anode_q         <= ANODE_ALL_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            encoded_q       <= encoded_d;
            anode_q         <= anode_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign bus.encoded     = encoded_q;
    assign bus.anode       = anode_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (4 digits, 8-cycle slots, 2 blank
// cycles). Models the downstream registered cathode decoder to check that
// the cathode value matches the digit whenever an anode is asserted.
`timescale 1ns/1ps
module tb_seven_seg_scan;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * DIV;

    typedef struct {
        string      name;
        logic [15:0] word;
        logic [3:0]  en;
        logic [3:0]  lit_nolz;
        logic [3:0]  lit_lz;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] cath;
    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[7];

    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream registered decoder: cathodes follow encoded one cycle late.
    always @(posedge clk) cath <= bus.encoded;

    function automatic logic [3:0] pick(input logic [3:0] nolz, input logic [3:0] lz);
`ifdef SEG_LZ_BLANK_EN
        return lz;
`else
        return nolz;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fs(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME + 8 && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_start;
        end
        check({name, " frame_start_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // Checks cycles k0..FRAME-1 of a frame, starting at the negedge of
    // cycle k0; optional loads are driven during cycles ld1_k / ld2_k.
    // Ends at cycle 0 of the next frame and checks frame_start there.
    task automatic check_frame(input string name, input int k0,
                               input logic [15:0] exp_word, input logic [3:0] exp_lit,
                               input int ld1_k, input logic [15:0] ld1_v,
                               input int ld2_k, input logic [15:0] ld2_v);
        int s, c;
        logic [3:0] exp_enc, exp_an, act_cath, exp_cath;
        logic       exp_fs;
        for (int k = k0; k < FRAME; k++) begin
            s = k / DIV;
            c = k % DIV;
            exp_enc = exp_word[s*4 +: 4];
            exp_an  = 4'hF;
            if (c >= BLANK && exp_lit[s]) exp_an[s] = 1'b0;
            exp_fs   = (k == 0);
            act_cath = (bus.anode == 4'hF) ? 4'h0 : cath;
            exp_cath = (exp_an == 4'hF) ? 4'h0 : exp_enc;
            check($sformatf("%s k=%0d {fs,enc,anode,cath}", name, k),
                  {19'd0, bus.frame_start, bus.encoded, bus.anode, act_cath},
                  {19'd0, exp_fs, exp_enc, exp_an, exp_cath});
            bus.load = 1'b0;
            if (k == ld1_k) begin bus.digits_in = ld1_v; bus.load = 1'b1; end
            if (k == ld2_k) begin bus.digits_in = ld2_v; bus.load = 1'b1; end
            @(negedge clk);
        end
        bus.load = 1'b0;
        check({name, " period"}, {31'd0, bus.frame_start}, 32'd1);
    endtask

    // From a frame_start cycle: set enables, load mid-frame, reach next frame.
    task automatic apply_vec(input string name, input logic [15:0] word, input logic [3:0] en);
        bus.digit_en = en;
        repeat (2) @(negedge clk);
        bus.digits_in = word;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        wait_fs(name);
    endtask

    initial begin
        vecs[0] = '{"v4321",    16'h4321, 4'hF,    4'hF,    4'hF};
        vecs[1] = '{"en0101",   16'h4321, 4'b0101, 4'b0101, 4'b0101};
        vecs[2] = '{"v0050",    16'h0050, 4'hF,    4'hF,    4'b0011};
        vecs[3] = '{"v0000",    16'h0000, 4'hF,    4'hF,    4'b0001};
        vecs[4] = '{"v8000",    16'h8000, 4'hF,    4'hF,    4'hF};
        vecs[5] = '{"v0B0A",    16'h0B0A, 4'b1110, 4'b1110, 4'b0110};
        vecs[6] = '{"v0900",    16'h0900, 4'b1011, 4'b1011, 4'b0011};

        bus.digits_in = '0;
        bus.load      = 1'b0;
        bus.digit_en  = 4'hF;

        // Reset state, then the first frame scans from digit 0.
        repeat (3) @(negedge clk);
        check("reset {fs,enc,anode}", {23'd0, bus.frame_start, bus.encoded, bus.anode},
              {23'd0, 1'b0, 4'h0, 4'hF});
        rst_n = 1'b1;
        @(negedge clk);
        check_frame("after_reset", 1, 16'h0000, pick(4'hF, 4'b0001), -1, '0, -1, '0);

        // Table of display patterns.
        for (int v = 0; v < 7; v++) begin
            apply_vec(vecs[v].name, vecs[v].word, vecs[v].en);
            check_frame(vecs[v].name, 0, vecs[v].word, pick(vecs[v].lit_nolz, vecs[v].lit_lz),
                        -1, '0, -1, '0);
        end

        // Two loads in one frame: current frame untouched, last load wins.
        apply_vec("pre_tear", 16'h4321, 4'hF);
        check_frame("tear_cur", 0, 16'h4321, 4'hF, 3, 16'hABCD, 10, 16'h00EF);
        check_frame("tear_next", 0, 16'h00EF, pick(4'hF, 4'b0011), -1, '0, -1, '0);

        // Load in the frame_start cycle: shown one frame later.
        check_frame("ld_at_fs", 0, 16'h00EF, pick(4'hF, 4'b0011), 0, 16'h4321, -1, '0);
        check_frame("ld_at_fs_next", 0, 16'h4321, 4'hF, -1, '0, -1, '0);

        // Reset mid-show: anodes off at once, scan restarts at digit 0.
        repeat (12) @(negedge clk);
        check("midshow anode", {28'd0, bus.anode}, {28'd0, 4'b1101});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset anode", {28'd0, bus.anode}, {28'd0, 4'hF});
        @(negedge clk);
        check("async_reset {fs,enc}", {27'd0, bus.frame_start, bus.encoded}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_frame("post_reset", 1, 16'h0000, pick(4'hF, 4'b0001), -1, '0, -1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
